// File: rtl/striping_pkg.sv
// Shared definitions for the two-lane striping / un-striping pair.
package striping_pkg;

  // Default data word width for both lanes and the input stream.
  localparam int WIDTH_DEF = 32;

  // Lane index constants, shared with un_striping.
  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  // Burst alignment state: where the next accepted word will be placed.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NEXT1 = 2'd1,
    NEXT0 = 2'd2
  } state_t;

endpackage

// File: rtl/striping_if.sv
// Word stream in, two lanes plus status out.
interface striping_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic [WIDTH-1:0] lane_0;
  logic             valid_0;
  logic [WIDTH-1:0] lane_1;
  logic             valid_1;
  logic             burst_odd;
  logic [CNT_W-1:0] word_count;

  // Word source side.
  modport master (
    output data_in, valid_in,
    input  lane_0, valid_0, lane_1, valid_1, burst_odd, word_count
  );

  // Striping block side.
  modport slave (
    input  data_in, valid_in,
    output lane_0, valid_0, lane_1, valid_1, burst_odd, word_count
  );
endinterface

// File: rtl/striping_idle_timer.sv
// Saturating count of consecutive idle cycles. expire is high in the cycle
// whose idle increment lands exactly on IDLE_TIMEOUT, so the caller can
// leave the burst on that same edge.
module striping_idle_timer #(
  parameter int IDLE_TIMEOUT = 2
) (
  input  logic clk_2f,
  input  logic reset,
  input  logic clear,
  output logic expire
);

  localparam logic [3:0] TC = 4'(IDLE_TIMEOUT);

  logic [3:0] cnt_r;
  logic [3:0] cnt_nxt_s;

  // Next count: clear on a word, otherwise count up and stop at the timeout.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (clear) begin
      cnt_nxt_s = 4'd0;
    end else if (cnt_r < TC) begin
      cnt_nxt_s = cnt_r + 4'd1;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Idle counter register.
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      cnt_r <= 4'd0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  // A word in the same cycle always wins over the timeout.
  assign expire = !clear && ((cnt_r + 4'd1) == TC);

endmodule

// File: rtl/striping.sv
// Distributes a single word stream alternately onto two lanes, lane_0 first,
// re-aligning to lane_0 after an idle gap of IDLE_TIMEOUT cycles.
module striping
  import striping_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEF,
  parameter int IDLE_TIMEOUT = 2,
  parameter int CNT_W        = 16
) (
  input  logic       clk_2f,
  input  logic       reset,
  striping_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_r,      state_nxt_s;
  logic [WIDTH-1:0] lane_0_r,     lane_0_nxt_s;
  logic [WIDTH-1:0] lane_1_r,     lane_1_nxt_s;
  logic             valid_0_r,    valid_0_nxt_s;
  logic             valid_1_r,    valid_1_nxt_s;
  logic             burst_odd_r,  burst_odd_nxt_s;
  logic [CNT_W-1:0] word_cnt_r,   word_cnt_nxt_s;
  logic             lane_sel_s;
  logic             expire_s;

  striping_idle_timer #(
    .IDLE_TIMEOUT (IDLE_TIMEOUT)
  ) u_idle_timer (
    .clk_2f (clk_2f),
    .reset  (reset),
    .clear  (bus.valid_in),
    .expire (expire_s)
  );

  // Lane placement, alignment state and counter next-values.
  always_comb begin
    state_nxt_s     = state_r;
    lane_0_nxt_s    = lane_0_r;
    lane_1_nxt_s    = lane_1_r;
    valid_0_nxt_s   = 1'b0;
    valid_1_nxt_s   = 1'b0;
    burst_odd_nxt_s = 1'b0;
    word_cnt_nxt_s  = word_cnt_r;
    lane_sel_s      = (state_r == NEXT1) ? LANE1 : LANE0;

    if (bus.valid_in) begin
      if (word_cnt_r != CNT_MAX) begin
        word_cnt_nxt_s = word_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        word_cnt_nxt_s = word_cnt_r;
      end
      case (lane_sel_s)
        LANE0: begin
          lane_0_nxt_s  = bus.data_in;
          valid_0_nxt_s = 1'b1;
          state_nxt_s   = NEXT1;
        end
        LANE1: begin
          lane_1_nxt_s  = bus.data_in;
          valid_1_nxt_s = 1'b1;
          state_nxt_s   = NEXT0;
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt_s = IDLE;
        end
        NEXT1: begin
          // Last word went to lane_0: the burst had an odd word count.
          if (expire_s) begin
            state_nxt_s     = IDLE;
            burst_odd_nxt_s = 1'b1;
          end else begin
            state_nxt_s = NEXT1;
          end
        end
        NEXT0: begin
          if (expire_s) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = NEXT0;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      lane_0_r    <= {WIDTH{1'b0}};
      lane_1_r    <= {WIDTH{1'b0}};
      valid_0_r   <= 1'b0;
      valid_1_r   <= 1'b0;
      burst_odd_r <= 1'b0;
      word_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      lane_0_r    <= lane_0_nxt_s;
      lane_1_r    <= lane_1_nxt_s;
      valid_0_r   <= valid_0_nxt_s;
      valid_1_r   <= valid_1_nxt_s;
      burst_odd_r <= burst_odd_nxt_s;
      word_cnt_r  <= word_cnt_nxt_s;
    end
  end

  assign bus.lane_0     = lane_0_r;
  assign bus.lane_1     = lane_1_r;
  assign bus.valid_0    = valid_0_r;
  assign bus.valid_1    = valid_1_r;
  assign bus.burst_odd  = burst_odd_r;
  assign bus.word_count = word_cnt_r;

endmodule

// File: tb/tb_striping.sv
// Scoreboard bench for striping: a burst-position model predicts lane
// placement, burst_odd and word_count; a monitor checks what the DUT shows.
module tb_striping;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 2;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    int              due;
    logic            v0;
    logic            v1;
    logic            odd;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] l0;
    logic [WIDTH-1:0] l1;
  } cyc_t;

  typedef struct {
    int               lane;
    logic [WIDTH-1:0] data;
  } word_t;

  logic clk_2f = 1'b0;
  logic reset  = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  cyc_t  cq[$];
  word_t wq[$];

  // Reference model: position within the current burst and idle gap length.
  int               pos    = 0;
  int               gap    = 0;
  int               mcount = 0;
  logic [WIDTH-1:0] ml0    = '0;
  logic [WIDTH-1:0] ml1    = '0;

  striping_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  striping #(
    .WIDTH        (WIDTH),
    .IDLE_TIMEOUT (TIMEOUT),
    .CNT_W        (CNT_W)
  ) dut (
    .clk_2f (clk_2f),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_2f = ~clk_2f;

  always @(posedge clk_2f) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    pos = 0; gap = 0; mcount = 0; ml0 = '0; ml1 = '0;
    cq.delete();
    wq.delete();
  endtask

  // Present one cycle of stimulus and record what must come out after the edge.
  task automatic drive(input logic v, input logic [WIDTH-1:0] d);
    cyc_t  e;
    word_t w;
    @(posedge clk_2f);
    #1;
    bus.valid_in = v;
    bus.data_in  = d;
    e.due = cyc + 1;
    e.v0 = 1'b0; e.v1 = 1'b0; e.odd = 1'b0;
    if (v) begin
      w.lane = pos % 2;
      w.data = d;
      if (w.lane == 0) begin e.v0 = 1'b1; ml0 = d; end
      else             begin e.v1 = 1'b1; ml1 = d; end
      wq.push_back(w);
      pos++;
      gap = 0;
      if (mcount < CNT_MAX) mcount++;
    end else begin
      gap++;
      if (gap == TIMEOUT && pos > 0) begin
        e.odd = (pos % 2 == 1);
        pos = 0;
      end
    end
    e.cnt = CNT_W'(mcount);
    e.l0  = ml0;
    e.l1  = ml1;
    cq.push_back(e);
  endtask

  // Monitor: per-cycle status check plus in-order word check on each valid.
  always @(negedge clk_2f) begin : mon
    cyc_t  e;
    word_t w;
    if (!reset) begin
      chk("lane_exclusive", {31'b0, bus.valid_0 & bus.valid_1}, 32'd0);
      if (cq.size() > 0 && cq[0].due == cyc) begin
        e = cq.pop_front();
        chk("valid_0",    {31'b0, bus.valid_0},   {31'b0, e.v0});
        chk("valid_1",    {31'b0, bus.valid_1},   {31'b0, e.v1});
        chk("burst_odd",  {31'b0, bus.burst_odd}, {31'b0, e.odd});
        chk("word_count", 32'(bus.word_count),    32'(e.cnt));
        chk("lane_0_hold", bus.lane_0, e.l0);
        chk("lane_1_hold", bus.lane_1, e.l1);
      end
      if (bus.valid_0) begin
        if (wq.size() == 0) chk("unexpected_valid_0", 32'd1, 32'd0);
        else begin
          w = wq.pop_front();
          chk("word_lane_0", 32'(w.lane), 32'd0);
          chk("word_data_0", bus.lane_0, w.data);
        end
      end
      if (bus.valid_1) begin
        if (wq.size() == 0) chk("unexpected_valid_1", 32'd1, 32'd0);
        else begin
          w = wq.pop_front();
          chk("word_lane_1", 32'(w.lane), 32'd1);
          chk("word_data_1", bus.lane_1, w.data);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_lane_0"},     bus.lane_0, 32'd0);
    chk({tag, "_lane_1"},     bus.lane_1, 32'd0);
    chk({tag, "_valid_0"},    {31'b0, bus.valid_0}, 32'd0);
    chk({tag, "_valid_1"},    {31'b0, bus.valid_1}, 32'd0);
    chk({tag, "_burst_odd"},  {31'b0, bus.burst_odd}, 32'd0);
    chk({tag, "_word_count"}, 32'(bus.word_count), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stim
    logic [WIDTH-1:0] four_words [4];
    four_words[0] = 32'hFFFF_FFFF;
    four_words[1] = 32'hEEEE_EEEE;
    four_words[2] = 32'hDDDD_DDDD;
    four_words[3] = 32'hCCCC_CCCC;

    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    repeat (2) @(posedge clk_2f);
    #1 reset = 1'b0;
    check_all_zero("reset");
    model_reset();

    // Back-to-back stream, even burst.
    for (int i = 0; i < 4; i++) drive(1'b1, four_words[i]);
    idle(3);

    // Odd burst ends on lane_0, then re-aligns to lane_0.
    for (int i = 1; i <= 3; i++) drive(1'b1, WIDTH'(i));
    idle(2);
    drive(1'b1, 32'h0000_0004);
    idle(3);

    // Short gap keeps alignment; word arriving as the timeout would hit wins.
    for (int i = 1; i <= 3; i++) drive(1'b1, WIDTH'(i));
    idle(1);
    drive(1'b1, 32'h0000_0004);
    idle(3);

    // Asynchronous reset mid-burst.
    drive(1'b1, 32'h1111_1111);
    drive(1'b1, 32'h2222_2222);
    drive(1'b1, 32'hAAAA_AAAA);
    @(posedge clk_2f);
    #2;
    chk("pre_reset_lane_0", bus.lane_0, 32'hAAAA_AAAA);
    #1;
    reset = 1'b1;
    bus.valid_in = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(posedge clk_2f);
    #1 reset = 1'b0;
    drive(1'b1, 32'h0000_0003);
    idle(3);

    // Counter saturation with continuous traffic.
    for (int i = 0; i < 20; i++) drive(1'b1, $urandom);
    idle(3);
    chk("word_count_saturated", 32'(bus.word_count), 32'(CNT_MAX));

    // Random traffic with random gap lengths around the timeout.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 2) != 0) drive(1'b1, $urandom);
      else idle($urandom_range(1, 3));
    end
    idle(4);

    repeat (2) @(posedge clk_2f);
    @(negedge clk_2f);
    #1;
    chk("words_outstanding",  32'(wq.size()), 32'd0);
    chk("cycles_outstanding", 32'(cq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/striping.md
Name: striping

Overview:
- Transmit-side counterpart of the two-lane un-striping block. It takes a single 32-bit word stream and distributes consecutive valid words alternately onto lane_0 and lane_1, starting with lane_0.
- Runs entirely in the clk_2f domain and feeds the lane inputs of un_striping.
- Tracks burst alignment, so every burst restarts on lane_0 after an idle gap.
- Reports odd-length bursts and a running word count.

Parameters:
- WIDTH, 32, data word width for data_in, lane_0 and lane_1.
- IDLE_TIMEOUT, 2, consecutive invalid cycles after which lane alignment returns to lane_0; legal range 1..15.
- CNT_W, 16, width of the saturating word counter.

Ports:
- clk_2f  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- data_in  in  WIDTH  input word, sampled when valid_in=1.
- valid_in  in  1  qualifies data_in for the current cycle.
- lane_0  out  WIDTH  registered lane 0 word; holds its last value when not updated.
- valid_0  out  1  high for exactly the cycle after lane_0 is loaded.
- lane_1  out  WIDTH  registered lane 1 word; holds its last value when not updated.
- valid_1  out  1  high for exactly the cycle after lane_1 is loaded.
- burst_odd  out  1  one-cycle pulse when a burst ends on lane_0 (odd word count).
- word_count  out  CNT_W  total valid words accepted since reset, saturating.

Behaviour:
- Reset values (applied asynchronously): lane_0=0, lane_1=0, valid_0=0, valid_1=0, burst_odd=0, word_count=0, state=IDLE, idle counter=0.
- FSM states:
  - IDLE: no burst in progress; next word goes to lane_0.
  - NEXT1: mid-burst; next word goes to lane_1.
  - NEXT0: mid-burst; next word goes to lane_0.
- FSM transitions on valid_in=1:
  - IDLE->NEXT1 and NEXT0->NEXT1: lane_0<=data_in, valid_0<=1, valid_1<=0.
  - NEXT1->NEXT0: lane_1<=data_in, valid_1<=1, valid_0<=0.
  - Idle counter clears to 0.
- FSM behaviour on valid_in=0:
  - valid_0<=0, valid_1<=0; lane data held.
  - Idle counter increments, saturating at IDLE_TIMEOUT.
  - When the increment reaches IDLE_TIMEOUT in NEXT1 or NEXT0, state<=IDLE.
  - If that exit is from NEXT1, burst_odd pulses high for one cycle, coincident with the IDLE transition.
  - In IDLE the counter simply saturates; no pulse.
- Latency: data_in sampled at edge N appears on its lane, with the lane valid high, from edge N to edge N+1. Fixed latency of 1 cycle; no backpressure. The block accepts a word every cycle.
- Lane fairness: within a burst, valid_0 and valid_1 never assert in the same cycle. Lane order is strictly 0,1,0,1,...
- word_count:
  - Increments by 1 on each accepted valid word.
  - At 2^CNT_W-1 it holds; no wrap.
- Boundary conditions:
  - An invalid gap shorter than IDLE_TIMEOUT preserves alignment: a burst of 3 words with a 1-cycle gap, then 1 more word, continues on lane_1.
  - valid_in=1 arriving in the same cycle the idle counter would reach IDLE_TIMEOUT: the word wins, the counter clears, no IDLE transition and no burst_odd.
  - Reset asserted mid-burst: all outputs clear at once; after release, the first word goes to lane_0.
  - Reset release is synchronous to the design via the bench; no synchronizer is inside this block.
- Round-trip property: a stream through striping then un_striping reproduces the original word order.

Decomposition:
- Shared package (e.g. striping_pkg): state enum {IDLE, NEXT1, NEXT0}, default WIDTH, and lane index constants LANE0=0, LANE1=1. un_striping imports the same constants.
- One natural sub-module: striping_idle_timer, the saturating idle counter with a terminal-count output, parameterised by IDLE_TIMEOUT.
- Lane registers, valid generation and word_count remain in the top.

Test Plan:
- Reset then stream FFFFFFFF, EEEEEEEE, DDDDDDDD, CCCCCCCC on consecutive cycles -> lane_0=FFFFFFFF/valid_0, lane_1=EEEEEEEE/valid_1, lane_0=DDDDDDDD, lane_1=CCCCCCCC on successive cycles at 1-cycle latency; word_count=4; no burst_odd.
- Burst 00000001, 00000002, 00000003, then valid_in=0 for 2 cycles -> lanes 0,1,0; burst_odd pulses exactly once on the second idle cycle; next word 00000004 lands on lane_0.
- Burst of 3 words, 1 idle cycle, then 00000004 (IDLE_TIMEOUT=2) -> 00000004 lands on lane_1; no burst_odd.
- Reset asserted asynchronously between clock edges mid-burst after lane_0=AAAAAAAA -> all outputs 0 before the next edge; after release, word 00000003 lands on lane_0.
- Word counter saturation with CNT_W=4, 20 valid words -> word_count reaches 15 and holds; lane alternation continues unaffected.
- Loopback with un_striping on 16 random words and random 1-cycle gaps -> data_out sequence equals the input sequence; the striping output matches data_out_synth.
